// File: rtl/lane_mux_pkg.sv
// Shared types and helpers for the lane_mux_rr channel multiplexer.
package lane_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Index width for n channels; never narrower than one bit.
   function automatic int unsigned cw_of(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/lane_mux_rr_if.sv
// Handshake bundle between lane_mux_rr and its upstream channels / downstream sink.
interface lane_mux_rr_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned LANES = 4,
   parameter int unsigned W     = 1
);
   localparam int unsigned CW = lane_mux_pkg::cw_of(NCH);
   localparam int unsigned DW = LANES * W;

   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [CW-1:0]     sel;
   logic              mode;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     out_ch;

   modport master (
      output in_data, in_valid, sel, mode, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, sel, mode, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/lane_mux_rr_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr, wrapping. Only built when
// LANE_MUX_RR_RR_EN is defined.
`ifdef LANE_MUX_RR_RR_EN
module rr_arbiter #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  idx
);
   logic [CW-1:0] cand;
   logic          found;

   // Scan ptr+1 .. ptr+NCH so the last winner gets lowest priority.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         cand = CW'((32'(ptr) + i) % NCH);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end
endmodule
`endif

// File: rtl/lane_mux_rr.sv
// Multi-lane channel mux with registered output; fixed select, plus round-robin
// arbitration when LANE_MUX_RR_RR_EN is defined.
module lane_mux_rr
   import lane_mux_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned LANES = 4,
   parameter int unsigned W     = 1
) (
   input logic         clk,
   input logic         rst_n,
   lane_mux_rr_if.slave bus
);
   localparam int unsigned CW = cw_of(NCH);
   localparam int unsigned DW = LANES * W;

   logic [NCH-1:0] fix_bits;
   logic           sel_ok;
   logic           fix_req;
   logic [NCH-1:0] gnt;
   logic [CW-1:0]  gidx;
   logic           load_en;
   logic [NCH-1:0] in_ready_c;
   logic           xfer;

   logic [DW-1:0]  out_data_q;
   logic [CW-1:0]  out_ch_q;
   logic           out_valid_q;

   assign sel_ok   = (32'(bus.sel) < NCH);
   assign fix_bits = bus.in_valid >> bus.sel;
   assign fix_req  = sel_ok & fix_bits[0];

`ifdef LANE_MUX_RR_RR_EN
   logic [CW-1:0]  ptr_q;
   logic [NCH-1:0] rr_gnt;
   logic [CW-1:0]  rr_idx;
   logic           rr_mode;

   assign rr_mode = (mode_e'(bus.mode) == MODE_RR);

   rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
      .req (bus.in_valid),
      .ptr (ptr_q),
      .gnt (rr_gnt),
      .idx (rr_idx)
   );

   // Pointer follows the last round-robin winner; fixed-mode traffic leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr_q <= CW'(NCH - 1);
      else if (xfer && rr_mode) ptr_q <= gidx;
   end
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
`endif

   // Grant selection for the current cycle.
   always_comb begin
      gnt  = fix_req ? (NCH'(1) << bus.sel) : '0;
      gidx = bus.sel;
`ifdef LANE_MUX_RR_RR_EN
      if (rr_mode) begin
         gnt  = rr_gnt;
         gidx = rr_idx;
      end
`endif
   end

   // Reset gating keeps in_ready quiet while the register is held in reset.
   assign load_en    = rst_n && (!out_valid_q || bus.out_ready);
   assign in_ready_c = load_en ? gnt : '0;
   assign xfer       = |(in_ready_c & bus.in_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else if (xfer) begin
         out_data_q  <= bus.in_data[32'(gidx) * DW +: DW];
         out_ch_q    <= gidx;
         out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_lane_mux_rr.sv
// Directed bench for lane_mux_rr (NCH=4 and NCH=3 instances); expectations
// follow LANE_MUX_RR_RR_EN so both builds are checked.
module tb_lane_mux_rr;

`ifdef LANE_MUX_RR_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [3:0] d4 [0:3];
   logic [3:0] d3 [0:2];
   int   seq_ch [0:4];

   always #5 clk = ~clk;

   lane_mux_rr_if #(.NCH(4), .LANES(4), .W(1)) b4 ();
   lane_mux_rr_if #(.NCH(3), .LANES(4), .W(1)) b3 ();

   lane_mux_rr #(.NCH(4), .LANES(4), .W(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
   lane_mux_rr #(.NCH(3), .LANES(4), .W(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      d4[0] = 4'h5; d4[1] = 4'h3; d4[2] = 4'hA; d4[3] = 4'hC;
      d3[0] = 4'h1; d3[1] = 4'h6; d3[2] = 4'h9;

      rst_n        = 1'b0;
      b4.in_data   = {d4[3], d4[2], d4[1], d4[0]};
      b4.in_valid  = 4'b0100;
      b4.sel       = 2'd2;
      b4.mode      = 1'b0;
      b4.out_ready = 1'b1;
      b3.in_data   = {d3[2], d3[1], d3[0]};
      b3.in_valid  = 3'b111;
      b3.sel       = 2'd0;
      b3.mode      = 1'b0;
      b3.out_ready = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("rst_in_ready",  32'(b4.in_ready),  32'h0);
      chk("rst_out_valid", 32'(b4.out_valid), 32'h0);
      chk("rst_out_data",  32'(b4.out_data),  32'h0);
      chk("rst_out_ch",    32'(b4.out_ch),    32'h0);
      #2 rst_n = 1'b1;
      #1;

      // Fixed select of ch2; NCH=3 instance selects ch0
      chk("fix_in_ready",    32'(b4.in_ready), 32'b0100);
      chk("n3_fix_in_ready", 32'(b3.in_ready), 32'b001);
      step();
      chk("fix_out_data",   32'(b4.out_data),  32'hA);
      chk("fix_out_ch",     32'(b4.out_ch),    32'd2);
      chk("fix_out_valid",  32'(b4.out_valid), 32'd1);
      chk("n3_out_valid",   32'(b3.out_valid), 32'd1);
      chk("n3_out_ch",      32'(b3.out_ch),    32'd0);
      chk("n3_out_data",    32'(b3.out_data),  32'h1);

      // Drain: no grant, accepted word clears valid but data/ch hold; sel>=NCH grants nothing
      b4.in_valid  = 4'b0000;
      b3.sel       = 2'd3;
      b3.out_ready = 1'b1;
      #1;
      chk("idle_in_ready",  32'(b4.in_ready), 32'h0);
      chk("n3_sel3_ready",  32'(b3.in_ready), 32'h0);
      step();
      chk("drain_valid",    32'(b4.out_valid), 32'd0);
      chk("drain_data",     32'(b4.out_data),  32'hA);
      chk("drain_ch",       32'(b4.out_ch),    32'd2);
      chk("n3_drain_valid", 32'(b3.out_valid), 32'd0);
      chk("n3_drain_data",  32'(b3.out_data),  32'h1);

      // Round-robin over all-valid: 0,1,2,3,0 back to back
      b4.mode     = 1'b1;
      b4.in_valid = 4'b1111;
      #1;
      chk("rr_first_ready", 32'(b4.in_ready), RR ? 32'b0001 : 32'b0100);
      seq_ch[0] = 0; seq_ch[1] = 1; seq_ch[2] = 2; seq_ch[3] = 3; seq_ch[4] = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("rr_seq_ch%0d", k),   32'(b4.out_ch),    RR ? 32'(seq_ch[k]) : 32'd2);
         chk($sformatf("rr_seq_data%0d", k), 32'(b4.out_data),  RR ? 32'(d4[seq_ch[k]]) : 32'hA);
         chk($sformatf("rr_seq_vld%0d", k),  32'(b4.out_valid), 32'd1);
      end

      // Stall three cycles with all inputs valid
      b4.out_ready = 1'b0;
      #1;
      chk("stall_ready0", 32'(b4.in_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall_ch%0d", k),    32'(b4.out_ch),    RR ? 32'd0 : 32'd2);
         chk($sformatf("stall_data%0d", k),  32'(b4.out_data),  RR ? 32'h5 : 32'hA);
         chk($sformatf("stall_vld%0d", k),   32'(b4.out_valid), 32'd1);
         chk($sformatf("stall_ready%0d", k), 32'(b4.in_ready),  32'h0);
      end
      b4.out_ready = 1'b1;
      #1;
      chk("resume_ready", 32'(b4.in_ready), RR ? 32'b0010 : 32'b0100);
      step();
      chk("resume_ch1", 32'(b4.out_ch), RR ? 32'd1 : 32'd2);
      step();
      chk("resume_ch2", 32'(b4.out_ch), 32'd2);

      // Reset mid-stream: immediate clear, first grant afterwards is ch0
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(b4.out_valid), 32'd0);
      chk("mid_rst_data",  32'(b4.out_data),  32'h0);
      chk("mid_rst_ch",    32'(b4.out_ch),    32'd0);
      chk("mid_rst_ready", 32'(b4.in_ready),  32'h0);
      @(posedge clk); #3 rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(b4.in_ready), RR ? 32'b0001 : 32'b0100);
      step();
      chk("post_rst_ch",    32'(b4.out_ch),    RR ? 32'd0 : 32'd2);
      chk("post_rst_valid", 32'(b4.out_valid), 32'd1);

      // Sparse requests from ptr=3: 1, 3, 1 (wrap)
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      b4.in_valid = 4'b1010;
      #1;
      chk("sparse_ready", 32'(b4.in_ready), RR ? 32'b0010 : 32'b0000);
      step();
      chk("sparse_vld", 32'(b4.out_valid), RR ? 32'd1 : 32'd0);
      chk("sparse_ch0", 32'(b4.out_ch),    RR ? 32'd1 : 32'd0);
      step();
      chk("sparse_ch1", 32'(b4.out_ch),    RR ? 32'd3 : 32'd0);
      step();
      chk("sparse_ch2", 32'(b4.out_ch),    RR ? 32'd1 : 32'd0);

      // Fixed-mode transfer must not move the round-robin pointer
      b4.mode = 1'b0;
      b4.sel  = 2'd3;
      #1;
      chk("fix3_ready", 32'(b4.in_ready), 32'b1000);
      step();
      chk("fix3_ch",   32'(b4.out_ch),   32'd3);
      chk("fix3_data", 32'(b4.out_data), 32'hC);
      b4.sel = 2'd0;
      #1;
      chk("fix0_ready", 32'(b4.in_ready), 32'h0);
      step();
      chk("fix0_valid", 32'(b4.out_valid), 32'd0);
      b4.mode = 1'b1;
      #1;
      chk("ptr_kept_ready", 32'(b4.in_ready), RR ? 32'b1000 : 32'b0000);
      step();
      chk("ptr_kept_ch", 32'(b4.out_ch), RR ? 32'd3 : 32'd3);
      chk("ptr_kept_vld", 32'(b4.out_valid), RR ? 32'd1 : 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lane_mux_rr.md
LANE_MUX_RR -- requirements
Module: lane_mux_rr

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of input channels (2..16).
REQ-002 The block SHALL have parameter LANES, default 4, meaning lanes per channel.
REQ-003 The block SHALL have parameter W, default 1, meaning bits per lane.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  NCH*LANES*W  channel c occupies bits [c*LANES*W +: LANES*W].
REQ-008 in_valid  input  NCH  per-channel data valid.
REQ-009 in_ready  output  NCH  per-channel accept; one-hot or zero.
REQ-010 sel  input  CW=max(1,$clog2(NCH))  channel select in fixed mode.
REQ-011 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-012 out_data  output  LANES*W  registered selected channel data.
REQ-013 out_valid  output  1  out_data holds an untaken word.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_ch  output  CW  source channel of current out_data.

Function
REQ-016 load_en SHALL be (!out_valid || out_ready); the output register SHALL load only when load_en and a grant exists.
REQ-017 Fixed mode: grant SHALL be channel sel when in_valid[sel]=1 and sel<NCH; sel>=NCH SHALL produce no grant and in_ready=0.
REQ-018 Round-robin mode: grant SHALL be the first channel with in_valid=1 scanning ptr+1, ptr+2, ... wrapping modulo NCH.
REQ-019 in_ready[g] SHALL be 1 only for granted channel g and only when load_en=1; all other bits 0; in_ready is combinational.
REQ-020 On a transfer (in_valid[g] && in_ready[g]) out_data SHALL take channel g lanes, out_ch SHALL take g, out_valid SHALL be 1 on the next edge (latency 1 cycle).
REQ-021 ptr SHALL update to g only on a transfer in round-robin mode; fixed-mode transfers SHALL leave ptr unchanged.
REQ-022 When out_valid && out_ready and no grant, out_valid SHALL clear next edge; out_data/out_ch SHALL hold.
REQ-023 When out_valid && !out_ready, out_data, out_ch, out_valid SHALL hold and in_ready SHALL be all 0.
REQ-024 Simultaneous output accept and new transfer SHALL yield back-to-back words, one per cycle, with no bubble.
REQ-025 mode or sel changes SHALL affect only the grant computed in the same cycle; no word in flight is lost or duplicated.

Reset
REQ-026 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_ch=0, ptr=NCH-1 (channel 0 first priority).
REQ-027 During reset in_ready SHALL be all 0; reset asserted mid-transfer SHALL discard the held word.

Configuration
REQ-028 Macro LANE_MUX_RR_RR_EN defined SHALL compile in round-robin mode and ptr; undefined, mode SHALL be ignored, ptr absent, and behaviour identical to fixed mode.

Structure
REQ-029 Package lane_mux_pkg SHALL hold the mode enum (MODE_FIXED=0, MODE_RR=1) and a clog2-based width helper constant function.
REQ-030 Sub-module rr_arbiter (request vector, ptr in, one-hot grant plus index out) SHALL be instantiated only under LANE_MUX_RR_RR_EN.

Verification
REQ-031 Reset release, NCH=4, mode=0, sel=2, in_valid=4'b0100, ch2 data 4'hA, out_ready=1 -> in_ready=4'b0100, next cycle out_data=4'hA, out_ch=2, out_valid=1.
REQ-032 mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 mode=1, ptr=3, in_valid=4'b1010 -> grant ch1, then ch3, then ch1 (wrap).
REQ-034 out_valid=1, out_ready=0 for 3 cycles with all inputs valid -> in_ready=0, out_data stable; out_ready=1 -> one transfer per cycle resumes.
REQ-035 NCH=3, mode=0, sel=3 -> in_ready=0, out_valid clears after pending word accepted.
REQ-036 rst_n pulsed low mid-stream -> out_valid=0 immediately, first post-reset round-robin grant is ch0.
